// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson (twisted-ring) sequence generator.
// Functions take the ring width at call time and operate on a code
// zero-extended to JC_MAXW bits, so one set serves every WIDTH.
package johnson_pkg;

  localparam int unsigned JC_MAXW = 32;

  typedef enum logic {
    JC_DIR_REV = 1'b0,
    JC_DIR_FWD = 1'b1
  } jc_dir_e;

  // Johnson code of phase p for a ring of w bits.
  function automatic logic [JC_MAXW-1:0] jc_phase_to_code(input int unsigned p,
                                                          input int unsigned w);
    logic [JC_MAXW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < JC_MAXW; i++) begin
      if (i < w) begin
        if (p < w) c[i] = (i < p);
        else       c[i] = (i >= p - w);
      end
    end
    return c;
  endfunction

  // Phase of a legal code; illegal codes give a phase whose code differs.
  function automatic int unsigned jc_code_to_phase(input logic [JC_MAXW-1:0] code,
                                                   input int unsigned w);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < JC_MAXW; i++) begin
      if (i < w && code[i]) ones++;
    end
    if (code[0] || ones == 0) return ones;
    else                      return 2 * w - ones;
  endfunction

  // A code is legal exactly when it round-trips through its phase.
  function automatic logic jc_is_legal(input logic [JC_MAXW-1:0] code,
                                       input int unsigned w);
    return (code == jc_phase_to_code(jc_code_to_phase(code, w), w));
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a raw Johnson code: legality, phase index, one-hot.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   code,
  output logic               legal,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_oh
);

  logic [JC_MAXW-1:0] code_ext;

  assign code_ext = JC_MAXW'(code);

  // Derive legality, phase and its one-hot from the code.
  always_comb begin
    legal    = jc_is_legal(code_ext, WIDTH);
    phase    = PW'(jc_code_to_phase(code_ext, WIDTH));
    phase_oh = '0;
    for (int unsigned i = 0; i < 2 * WIDTH; i++) begin
      phase_oh[i] = (phase == PW'(i));
    end
  end

endmodule

// File: rtl/johnson_seq_gen.sv
// Bidirectional Johnson sequence generator with checked parallel load,
// registered phase index / one-hot, wrap pulse and load-error pulse.
module johnson_seq_gen
  import johnson_pkg::*;
#(
  parameter  int unsigned WIDTH       = 4,
  parameter  int unsigned RESET_PHASE = 0,
  localparam int unsigned PW          = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_code,
  output logic [WIDTH-1:0]   count,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_oh,
  output logic               wrap,
  output logic               load_err
);

  localparam int unsigned          NS         = 2 * WIDTH;
  localparam logic [WIDTH-1:0]     RESET_CODE = WIDTH'(jc_phase_to_code(RESET_PHASE, WIDTH));
  localparam logic [NS-1:0]        RESET_OH   = NS'(1) << RESET_PHASE;
  localparam logic [PW-1:0]        LAST_PHASE = PW'(NS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [NS-1:0]    phase_oh_q, phase_oh_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic             ld_legal;
  logic [PW-1:0]    ld_phase;
  logic [NS-1:0]    ld_phase_oh;
  jc_dir_e          dir_e;

  assign dir_e = jc_dir_e'(dir);

  johnson_decode #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_load_decode (
    .code     (load_code),
    .legal    (ld_legal),
    .phase    (ld_phase),
    .phase_oh (ld_phase_oh)
  );

  // Next-state mux: load > step > hold. The step path advances phase and
  // rotates the one-hot in lock-step with the shifted code, so all three
  // stay consistent without re-decoding the stepped code.
  always_comb begin
    count_d    = count_q;
    phase_d    = phase_q;
    phase_oh_d = phase_oh_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (ld_legal) begin
        count_d    = load_code;
        phase_d    = ld_phase;
        phase_oh_d = ld_phase_oh;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (dir_e == JC_DIR_FWD) begin
        count_d    = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        phase_d    = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
        phase_oh_d = {phase_oh_q[NS-2:0], phase_oh_q[NS-1]};
        wrap_d     = (phase_q == LAST_PHASE);
      end else begin
        count_d    = {~count_q[0], count_q[WIDTH-1:1]};
        phase_d    = (phase_q == '0) ? LAST_PHASE : phase_q - 1'b1;
        phase_oh_d = {phase_oh_q[0], phase_oh_q[NS-1:1]};
        wrap_d     = (phase_q == '0);
      end
    end
  end

  // Output registers with synchronous reset to RESET_PHASE.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= RESET_CODE;
      phase_q    <= PW'(RESET_PHASE);
      phase_oh_q <= RESET_OH;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      phase_q    <= phase_d;
      phase_oh_q <= phase_oh_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign phase    = phase_q;
  assign phase_oh = phase_oh_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Directed bench for johnson_seq_gen: a WIDTH=4 instance with hand-computed
// vectors and a WIDTH=5 / RESET_PHASE=7 instance against a phase model.
module tb_johnson_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4, RESET_PHASE=0
  logic       a_reset, a_en, a_dir, a_load;
  logic [3:0] a_load_code, a_count;
  logic [2:0] a_phase;
  logic [7:0] a_phase_oh;
  logic       a_wrap, a_load_err;

  // WIDTH=5, RESET_PHASE=7
  logic       b_reset, b_en, b_dir, b_load;
  logic [4:0] b_load_code, b_count;
  logic [3:0] b_phase;
  logic [9:0] b_phase_oh;
  logic       b_wrap, b_load_err;

  johnson_seq_gen #(.WIDTH(4), .RESET_PHASE(0)) dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .dir(a_dir), .load(a_load),
    .load_code(a_load_code), .count(a_count), .phase(a_phase),
    .phase_oh(a_phase_oh), .wrap(a_wrap), .load_err(a_load_err)
  );

  johnson_seq_gen #(.WIDTH(5), .RESET_PHASE(7)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .dir(b_dir), .load(b_load),
    .load_code(b_load_code), .count(b_count), .phase(b_phase),
    .phase_oh(b_phase_oh), .wrap(b_wrap), .load_err(b_load_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic a_step(input logic r, input logic l, input logic [3:0] lc,
                        input logic e, input logic d);
    a_reset = r; a_load = l; a_load_code = lc; a_en = e; a_dir = d;
    @(posedge clk);
    #1;
  endtask

  task automatic a_expect(input string tag, input logic [3:0] c, input logic [2:0] p,
                          input logic w, input logic le);
    chk({tag, ".count"}, 32'(a_count), 32'(c));
    chk({tag, ".phase"}, 32'(a_phase), 32'(p));
    chk({tag, ".oh"},    32'(a_phase_oh), 32'(8'd1 << p));
    chk({tag, ".wrap"},  32'(a_wrap), 32'(w));
    chk({tag, ".err"},   32'(a_load_err), 32'(le));
  endtask

  // Independent code model for the WIDTH=5 ring.
  function automatic logic [4:0] code5(input int p);
    if (p < 5) return 5'((1 << p) - 1);
    else       return 5'(31 & ~((1 << (p - 5)) - 1));
  endfunction

  logic [3:0] fwd_tab [8];
  int         mph;
  logic       m_wrap;

  initial begin
    fwd_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                4'b1110, 4'b1100, 4'b1000, 4'b0000};
    b_reset = 1'b1; b_en = 1'b0; b_dir = 1'b0; b_load = 1'b0; b_load_code = '0;

    // Reset
    a_step(1, 0, 4'h0, 0, 1);
    a_expect("reset", 4'b0000, 3'd0, 0, 0);

    // Forward through one full cycle; wrap only on the last step
    for (int i = 0; i < 8; i++) begin
      a_step(0, 0, 4'h0, 1, 1);
      a_expect("fwd", fwd_tab[i], 3'((i + 1) % 8), (i == 7), 0);
    end

    // Reverse across the boundary, then forward back: wrap on both
    a_step(0, 0, 4'h0, 1, 0);
    a_expect("rev_wrap", 4'b1000, 3'd7, 1, 0);
    a_step(0, 0, 4'h0, 1, 1);
    a_expect("fwd_rewrap", 4'b0000, 3'd0, 1, 0);
    a_step(0, 0, 4'h0, 1, 0);
    a_expect("rev_wrap2", 4'b1000, 3'd7, 1, 0);
    a_step(0, 0, 4'h0, 1, 0);
    a_expect("rev_step", 4'b1100, 3'd6, 0, 0);

    // Legal load overrides en
    a_step(0, 1, 4'b0111, 1, 1);
    a_expect("load_ok", 4'b0111, 3'd3, 0, 0);
    // Illegal load: state held, no step, error pulse
    a_step(0, 1, 4'b0101, 1, 1);
    a_expect("load_bad", 4'b0111, 3'd3, 0, 1);
    a_step(0, 0, 4'h0, 0, 1);
    a_expect("err_clear", 4'b0111, 3'd3, 0, 0);
    a_step(0, 1, 4'b1010, 0, 0);
    a_expect("load_bad2", 4'b0111, 3'd3, 0, 1);
    a_step(0, 1, 4'b1000, 0, 1);
    a_expect("load_top", 4'b1000, 3'd7, 0, 0);
    a_step(0, 1, 4'b1111, 0, 1);
    a_expect("load_ones", 4'b1111, 3'd4, 0, 0);

    // Step to phase 5 and hold
    a_step(0, 0, 4'h0, 1, 1);
    a_expect("to_p5", 4'b1110, 3'd5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      a_step(0, 0, 4'h0, 0, 1);
      a_expect("hold", 4'b1110, 3'd5, 0, 0);
    end

    // Reset beats load and en
    a_step(1, 1, 4'b0111, 1, 1);
    a_expect("reset_prio", 4'b0000, 3'd0, 0, 0);
    a_reset = 1'b1; a_en = 1'b0; a_load = 1'b0;

    // WIDTH=5, RESET_PHASE=7 random walk
    b_reset = 1'b1;
    @(posedge clk); #1;
    chk("b_reset.count", 32'(b_count), 32'(5'b11100));
    chk("b_reset.phase", 32'(b_phase), 32'd7);
    chk("b_reset.oh",    32'(b_phase_oh), 32'(10'd1 << 7));
    chk("b_reset.wrap",  32'(b_wrap), 32'd0);
    b_reset = 1'b0;
    mph = 7;
    for (int i = 0; i < 200; i++) begin
      b_dir = 1'($urandom_range(0, 1));
      b_en  = ($urandom_range(0, 3) != 0);
      m_wrap = 1'b0;
      if (b_en) begin
        if (b_dir) begin m_wrap = (mph == 9); mph = (mph + 1) % 10; end
        else       begin m_wrap = (mph == 0); mph = (mph + 9) % 10; end
      end
      @(posedge clk); #1;
      chk("b_walk.count", 32'(b_count), 32'(code5(mph)));
      chk("b_walk.phase", 32'(b_phase), 32'(mph));
      chk("b_walk.oh",    32'(b_phase_oh), 32'(10'd1 << mph));
      chk("b_walk.onehot", 32'($onehot(b_phase_oh)), 32'd1);
      chk("b_walk.wrap",  32'(b_wrap), 32'(m_wrap));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
